// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared state encoding, opcode constants and counter sizing for the serial ALU units.
package serial_alu_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full-adder cell used as the serial datapath element.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder_unit.sv
// serial_adder_unit: bit-serial add/subtract, one bit per clock, WIDTH+1 cycle latency.
// Define SERIAL_ADDER_OVF_EN to add the two's-complement overflow output ovf.
module serial_adder_unit
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = cnt_width(WIDTH);
  state_e           state_q;
  logic [WIDTH-1:0] shift_a_q, shift_b_q, res_q, res_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, cout_q;
  logic [WIDTH-1:0] sum_q;
  logic             fa_s, fa_c, last;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
  assign ovf = ovf_q;
`endif
  full_adder u_fa (
    .a   (shift_a_q[0]),
    .b   (shift_b_q[0]),
    .cin (carry_q),
    .sum (fa_s),
    .cout(fa_c)
  );
  assign res_d = {fa_s, res_q[WIDTH-1:1]};
  assign last  = cnt_q == CW'(WIDTH - 1);
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          shift_a_q <= a;
          shift_b_q <= (op_sub == OP_SUB) ? ~b : b;
          carry_q   <= (op_sub == OP_SUB) ? 1'b1 : cin;
          cnt_q     <= '0;
          res_q     <= '0;
          busy_q    <= 1'b1;
          state_q   <= ST_RUN;
        end
        ST_RUN: begin
          shift_a_q <= shift_a_q >> 1;
          shift_b_q <= shift_b_q >> 1;
          carry_q   <= fa_c;
          res_q     <= res_d;
          if (last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            sum_q   <= res_d;
            cout_q  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= carry_q ^ fa_c;
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_unit.sv
// tb_serial_adder_unit: randomized scoreboard bench for serial_adder_unit (WIDTH=8).
module tb_serial_adder_unit;
  localparam int W = 8;
  localparam int M = 1 << W;
  logic         clk, rst, start, op_sub, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif
  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           due;
  } exp_t;
  exp_t exp_q[$];
  exp_t last_exp;
  int   checks = 0, passed = 0, cyc = 0;
  logic prev_done = 1'b0;

  serial_adder_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op_sub(op_sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic exp_t model(input int av, input int bv, input int ci, input bit sub);
    exp_t e;
    int f, sa, sb, r;
    f   = sub ? av + M - bv : av + bv + ci;
    sa  = (av >= M / 2) ? av - M : av;
    sb  = (bv >= M / 2) ? bv - M : bv;
    r   = sub ? sa - sb : sa + sb + ci;
    e.s = W'(f % M);
    e.c = (f / M) != 0;
    e.v = (r > M / 2 - 1) || (r < -(M / 2));
    e.due = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation, on time.
  always @(negedge clk) begin
    if (prev_done) chk("busy_after_done", int'(busy), 0);
    if (done) begin
      if (exp_q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum", int'(sum), int'(e.s));
        chk("cout", int'(cout), int'(e.c));
        chk("latency", cyc, e.due);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", int'(ovf), int'(e.v));
`endif
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(input int av, input int bv, input int ci, input bit sub, input bit push);
    exp_t e;
    wait_idle();
    a = W'(av); b = W'(bv); cin = ci[0]; op_sub = sub; start = 1'b1;
    e = model(av, bv, ci, sub);
    e.due = cyc + 1 + W;
    if (push) begin
      exp_q.push_back(e);
      last_exp = e;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_cout", int'(cout), 0);
    rst = 1'b0;
    @(negedge clk);
    issue('h5A, 'h3C, 0, 1'b0, 1'b1);
    issue('hFF, 'h01, 0, 1'b0, 1'b1);
    issue('h00, 'h00, 1, 1'b0, 1'b1);
    issue('h10, 'h20, 1, 1'b1, 1'b1);
    issue('h20, 'h10, 0, 1'b1, 1'b1);
    issue('h7F, 'h01, 0, 1'b0, 1'b1);
    issue('h80, 'h01, 0, 1'b1, 1'b1);
    issue('h05, 'h03, 0, 1'b0, 1'b1);
    issue('h00, 'h00, 0, 1'b1, 1'b1);
    issue('hFF, 'hFF, 1, 1'b0, 1'b1);
    // Sum must hold while idle and inputs wander.
    wait_idle();
    repeat (3) begin
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
    end
    chk("hold_sum", int'(sum), int'(last_exp.s));
    chk("hold_cout", int'(cout), int'(last_exp.c));
    // Start held high with new operands through RUN and DONE is ignored.
    issue('hC3, 'h5A, 1, 1'b0, 1'b1);
    for (int i = 0; i <= W; i++) begin
      a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom); start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    // Reset mid-RUN discards the operation.
    issue('h33, 'h44, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_sum", int'(sum), 0);
    chk("midrst_cout", int'(cout), 0);
    chk("midrst_done", int'(done), 0);
    rst = 1'b0;
    repeat (W + 3) @(negedge clk);
    issue('h12, 'h34, 1, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++)
      issue(int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
            int'($urandom_range(0, 1)), 1'($urandom), 1'b1);
    begin
      int n = 0;
      while (exp_q.size() > 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/serial_adder_unit.md
Name: serial_adder_unit

Overview:
- Multi-cycle, bit-serial add/subtract unit for the CPU datapath. It consumes one bit of each operand per clock through a single one-bit full-adder cell and a registered carry.
- Sits directly downstream of operand select and feeds the ALU result mux.
- Trades latency (WIDTH+1 cycles) for area. It uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op_sub  input  1  0 = a+b+cin; 1 = a-b (cin ignored)
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in for add, captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result; holds until next accepted start or reset
- cout  output  1  carry-out of MSB; for subtract, 1 = no borrow

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state = IDLE; busy, done, sum, cout and all internal shift, carry and count registers = 0.
- rst dominates start and any in-flight operation. A mid-RUN reset discards the operation and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE, on edge k with start=1:
  - Load shift_a = a.
  - Load shift_b = op_sub ? ~b : b.
  - Load carry = op_sub ? 1 : cin.
  - Set bit count = 0, clear the result shift register, go to RUN.
- IDLE with start=0: stay in IDLE; outputs hold.
- RUN, each edge:
  - Full-adder cell computes s, c from shift_a[0], shift_b[0] and carry.
  - s shifts into the result register MSB (LSB-first, right shift).
  - carry <= c; shift_a and shift_b shift right; count increments.
  - On the edge where count reaches WIDTH-1 (the WIDTH-th bit), go to DONE.
  - Also on that edge: sum <= final result, cout <= c.
- Timing: bits are processed on edges k+1 .. k+WIDTH.
- DONE: done=1 for exactly one cycle (the cycle after edge k+WIDTH), then IDLE at edge k+WIDTH+1.
- Start-to-done latency: WIDTH+1 edges. Maximum throughput: one operation per WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored, not queued. Operand changes after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH; cout is the true (WIDTH+1)-th bit.
- The count register is $clog2(WIDTH) bits and saturates by state change, with no wrap.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), reset 0.
  - During the MSB cycle, capture ovf <= carry_in_to_MSB XOR carry_out_of_MSB (two's-complement overflow).
  - ovf updates with sum and holds with it.
- Undefined: port absent; no extra flops.

Decomposition:
- Shared package serial_alu_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - OP_ADD=1'b0 and OP_SUB=1'b1.
  - Counter-width function.
- Sub-module: one instance of full_adder (team's one-bit adder cell: a, b, cin -> sum, cout) as the serial datapath cell. All sequencing stays in serial_adder_unit.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, op_sub=0, start at edge 0 -> done high in the cycle after edge 8 only, sum=0x96, cout=0, busy low after edge 9.
- a=0xFF, b=0x01, cin=0, add -> sum=0x00, cout=1; also a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- op_sub=1, a=0x10, b=0x20, cin=1 (ignored) -> sum=0xF0, cout=0; a=0x20, b=0x10 -> sum=0x10, cout=1.
- Start accepted, then start=1 with new operands at edges 3 and 8 -> ignored; result matches the first operands; exactly one done pulse.
- rst=1 at edge 4 of RUN -> next cycle: busy=0, sum=0, cout=0, no done. A fresh start afterwards completes normally.
- With SERIAL_ADDER_OVF_EN:
  - a=0x7F, b=0x01 add -> sum=0x80, ovf=1.
  - a=0x80, b=0x01 sub -> sum=0x7F, ovf=1.
  - a=0x05, b=0x03 add -> ovf=0.
